// File: rtl/xfipcs_cdc_xfer_arb.sv
// xfipcs_cdc_xfer_arb: round-robin source-side controller for a toggle-handshake CDC channel.
// Rev 1.0 - launches one word per request toggle, waits for the synchronized ack toggle, flags overdue acks.
`default_nettype none

module xfipcs_cdc_xfer_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_grant,
  output logic [NREQ-1:0]   req_done,
  output logic [DW-1:0]     xfer_data,
  output logic [2:0]        xfer_src,
  output logic              xfer_tgl,
  input  logic              ack_tgl_async,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic       ST_IDLE = 1'b0;
  localparam logic       ST_WAIT = 1'b1;
  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_IDX = 3'(NREQ - 1);

  logic        ack_s1;
  logic        ack_s2;
  logic        state;
  logic        state_nxt;
  logic [2:0]  rr_ptr;
  logic [15:0] to_cnt;
  logic [2:0]  win_idx;
  logic        win_vld;
  logic        chan_idle;
  logic        launch;
  logic        finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= ack_tgl_async;
      ack_s2 <= ack_s1;
    end
  end

  assign chan_idle = (ack_s2 == xfer_tgl);

  // Scan downward so the requester closest to rr_ptr (cyclically) is the last to be written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_vld[idx]) begin
        win_vld = 1'b1;
        win_idx = 3'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (win_vld && chan_idle) state_nxt = ST_WAIT;
      ST_WAIT: if (chan_idle) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    launch = (state == ST_IDLE) && win_vld && chan_idle;
    finish = (state == ST_WAIT) && chan_idle;
    busy   = (state == ST_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_grant   <= '0;
      req_done    <= '0;
      xfer_data   <= '0;
      xfer_src    <= 3'd0;
      xfer_tgl    <= 1'b0;
      rr_ptr      <= 3'd0;
      to_cnt      <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      req_grant   <= '0;
      req_done    <= '0;
      timeout_err <= 1'b0;
      if (launch) begin
        xfer_data <= req_data[win_idx*DW +: DW];
        xfer_src  <= win_idx;
        xfer_tgl  <= ~xfer_tgl;
        req_grant <= NREQ'(1) << win_idx;
        rr_ptr    <= (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;
        to_cnt    <= 16'd0;
      end else if (finish) begin
        req_done <= NREQ'(1) << xfer_src;
      end else if (state == ST_WAIT && to_cnt != TO_MAX) begin
        // Counter saturates at TIMEOUT so the error fires exactly once per transfer.
        to_cnt <= to_cnt + 16'd1;
        if (to_cnt == TO_LAST) timeout_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xfipcs_cdc_xfer_arb.sv
// Directed self-checking bench for xfipcs_cdc_xfer_arb (NREQ=4, DW=16, TIMEOUT=8).
`default_nettype none

module tb_xfipcs_cdc_xfer_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_vld = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_grant;
  logic [3:0]  req_done;
  logic [15:0] xfer_data;
  logic [2:0]  xfer_src;
  logic        xfer_tgl;
  logic        ack_tgl_async = 1'b0;
  logic        busy;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  xfipcs_cdc_xfer_arb #(.NREQ(4), .DW(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
    .req_grant(req_grant), .req_done(req_done), .xfer_data(xfer_data),
    .xfer_src(xfer_src), .xfer_tgl(xfer_tgl), .ack_tgl_async(ack_tgl_async),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_vld = '0; req_data = '0; ack_tgl_async = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (req_grant != 4'b0) begin n = i; break; end
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (req_done != 4'b0) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    tests++; if (req_grant !== 4'b0 || req_done !== 4'b0) begin
      fails++; $display("FAIL reset_pulses: grant=%b done=%b expected 0000/0000", req_grant, req_done); end
    tests++; if (xfer_data !== 16'h0 || xfer_src !== 3'd0) begin
      fails++; $display("FAIL reset_xfer: data=%h src=%0d expected 0/0", xfer_data, xfer_src); end
    tests++; if (xfer_tgl !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      fails++; $display("FAIL reset_flags: tgl=%b busy=%b to=%b expected 0/0/0", xfer_tgl, busy, timeout_err); end
  endtask

  task automatic test_single;
    int n;
    do_reset;
    req_data[15:0] = 16'hA5A5; req_vld = 4'b0001;
    tick;
    tests++; if (req_grant !== 4'b0001) begin
      fails++; $display("FAIL single_grant: got %b expected 0001", req_grant); end
    tests++; if (xfer_data !== 16'hA5A5 || xfer_tgl !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL single_launch: data=%h tgl=%b busy=%b expected a5a5/1/1", xfer_data, xfer_tgl, busy); end
    req_vld = 4'b0;
    tick;
    tests++; if (req_grant !== 4'b0) begin
      fails++; $display("FAIL single_grant_pulse: got %b expected 0000", req_grant); end
    tick;
    ack_tgl_async = 1'b1;
    wait_done(n);
    tests++; if (n !== 3 || req_done !== 4'b0001) begin
      fails++; $display("FAIL single_done: latency=%0d done=%b expected 3/0001", n, req_done); end
    tests++; if (busy !== 1'b0) begin
      fails++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin;
    int n;
    logic [3:0] eg;
    do_reset;
    for (int e = 0; e < 4; e++) req_data[e*16 +: 16] = 16'hC000 + 16'(e);
    req_vld = 4'hF;
    for (int t = 0; t < 5; t++) begin
      int e;
      e = t % 4;
      eg = 4'b0001 << e;
      wait_grant(n);
      tests++; if (req_grant !== eg) begin
        fails++; $display("FAIL rr_grant%0d: got %b expected %b", t, req_grant, eg); end
      tests++; if (xfer_src !== 3'(e) || xfer_data !== 16'hC000 + 16'(e)) begin
        fails++; $display("FAIL rr_xfer%0d: src=%0d data=%h expected %0d/%h", t, xfer_src, xfer_data, e, 16'hC000 + 16'(e)); end
      ack_tgl_async = ~ack_tgl_async;
      wait_done(n);
      tests++; if (req_done !== eg || req_grant !== 4'b0) begin
        fails++; $display("FAIL rr_done%0d: done=%b grant=%b expected %b/0000", t, req_done, req_grant, eg); end
    end
    req_vld = 4'b0;
    tick;
  endtask

  task automatic test_fairness;
    int n;
    do_reset;
    req_vld = 4'b0010;
    wait_grant(n);
    tests++; if (req_grant !== 4'b0010) begin
      fails++; $display("FAIL fair_setup: got %b expected 0010", req_grant); end
    req_vld = 4'b0;
    ack_tgl_async = ~ack_tgl_async;
    wait_done(n);
    req_vld = 4'b0011;
    wait_grant(n);
    tests++; if (req_grant !== 4'b0001) begin
      fails++; $display("FAIL fair_first: got %b expected 0001", req_grant); end
    ack_tgl_async = ~ack_tgl_async;
    wait_done(n);
    wait_grant(n);
    tests++; if (req_grant !== 4'b0010) begin
      fails++; $display("FAIL fair_second: got %b expected 0010", req_grant); end
    req_vld = 4'b0;
    ack_tgl_async = ~ack_tgl_async;
    wait_done(n);
  endtask

  task automatic test_timeout;
    int pulses;
    int n;
    do_reset;
    req_vld = 4'b0001;
    tick;
    req_vld = 4'b0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      tests++; if (timeout_err !== (i == 8)) begin
        fails++; $display("FAIL timeout_cycle%0d: got %b expected %b", i, timeout_err, (i == 8)); end
    end
    tests++; if (busy !== 1'b1) begin
      fails++; $display("FAIL timeout_busy: got %b expected 1", busy); end
    ack_tgl_async = 1'b1;
    pulses = 0; n = 0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (timeout_err) pulses++;
      if (req_done != 4'b0) begin n = i; break; end
    end
    tests++; if (n !== 3 || req_done !== 4'b0001 || pulses !== 0) begin
      fails++; $display("FAIL timeout_done: latency=%0d done=%b extra_to=%0d expected 3/0001/0", n, req_done, pulses); end
  endtask

  task automatic test_reset_mid_wait;
    do_reset;
    req_data[47:32] = 16'hBEEF; req_vld = 4'b0100;
    tick;
    tests++; if (req_grant !== 4'b0100 || xfer_data !== 16'hBEEF) begin
      fails++; $display("FAIL rmw_launch: grant=%b data=%h expected 0100/beef", req_grant, xfer_data); end
    req_vld = 4'b0;
    ack_tgl_async = 1'b1;
    tick; tick;
    rst = 1'b1;
    #1;
    tests++; if (xfer_tgl !== 1'b0 || busy !== 1'b0 || xfer_data !== 16'h0 || xfer_src !== 3'd0 || req_done !== 4'b0) begin
      fails++; $display("FAIL rmw_async_clear: tgl=%b busy=%b data=%h src=%0d done=%b expected all 0", xfer_tgl, busy, xfer_data, xfer_src, req_done); end
    tick;
    rst = 1'b0;
    tick; tick; tick;
    req_vld = 4'b0100;
    for (int i = 1; i <= 3; i++) begin
      tick;
      tests++; if (req_grant !== 4'b0 || req_done !== 4'b0) begin
        fails++; $display("FAIL rmw_blocked%0d: grant=%b done=%b expected 0000/0000", i, req_grant, req_done); end
    end
    ack_tgl_async = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick;
      tests++; if (req_grant !== ((i == 3) ? 4'b0100 : 4'b0000)) begin
        fails++; $display("FAIL rmw_release%0d: got %b expected %b", i, req_grant, ((i == 3) ? 4'b0100 : 4'b0000)); end
    end
    req_vld = 4'b0;
    ack_tgl_async = 1'b1;
    tick; tick; tick; tick;
  endtask

  task automatic test_data_stability;
    int n;
    do_reset;
    req_data[15:0] = 16'h1111; req_vld = 4'b0001;
    tick;
    tests++; if (req_grant !== 4'b0001) begin
      fails++; $display("FAIL stab_grant: got %b expected 0001", req_grant); end
    for (int i = 1; i <= 6; i++) begin
      req_data = {$urandom(), $urandom()};
      req_vld = 4'($urandom());
      tick;
      tests++; if (xfer_data !== 16'h1111 || xfer_src !== 3'd0 || req_grant !== 4'b0) begin
        fails++; $display("FAIL stab_hold%0d: data=%h src=%0d grant=%b expected 1111/0/0000", i, xfer_data, xfer_src, req_grant); end
    end
    ack_tgl_async = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      req_data = {$urandom(), $urandom()};
      req_vld = 4'($urandom());
      tick;
      if (req_done != 4'b0) begin n = i; break; end
    end
    tests++; if (n !== 3 || req_done !== 4'b0001 || xfer_data !== 16'h1111 || xfer_src !== 3'd0) begin
      fails++; $display("FAIL stab_done: latency=%0d done=%b data=%h src=%0d expected 3/0001/1111/0", n, req_done, xfer_data, xfer_src); end
    req_vld = 4'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_fairness;
    test_timeout;
    test_reset_mid_wait;
    test_data_stability;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
